// File: rtl/nibble_serial_sub.sv
// Nibble-serial a - b - bin sequencer around one 4-bit subtractor.
// LSB nibble first, borrow chained through a register.
module fullhalfsub_4b (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       cin,
  output logic [3:0] d,
  output logic       bout
);

  logic [4:0] t;

  // Bit 4 of the 5-bit difference is set exactly when a < b + cin.
  assign t    = {1'b0, a} - {1'b0, b} - {4'b0, cin};
  assign d    = t[3:0];
  assign bout = t[4];

endmodule

module nibble_serial_sub #(
  parameter  int NIBBLES = 4,
  localparam int W       = 4 * NIBBLES,
  localparam int IW      = (NIBBLES > 1) ? $clog2(NIBBLES) : 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         bin,
  output logic         busy,
  output logic         done,
  output logic [W-1:0] diff,
  output logic         bout,
  output logic         zero
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } state_t;

  state_t        state;
  state_t        state_nxt;
  logic [W-1:0]  op_a;
  logic [W-1:0]  op_b;
  logic          borrow_r;
  logic [IW-1:0] idx;
  logic          accept;
  logic          step;
  logic          last;
  logic [3:0]    sa;
  logic [3:0]    sb_in;
  logic [3:0]    sd;
  logic          sbo;
  logic [W-1:0]  diff_upd;

  assign last  = (idx == IW'(NIBBLES - 1));
  assign sa    = op_a[4*idx +: 4];
  assign sb_in = op_b[4*idx +: 4];

  fullhalfsub_4b u_sub (
    .a    (sa),
    .b    (sb_in),
    .cin  (borrow_r),
    .d    (sd),
    .bout (sbo)
  );

  always_comb begin
    diff_upd             = diff;
    diff_upd[4*idx +: 4] = sd;
  end

  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    step      = 1'b0;
    case (state)
      S_IDLE: begin
        if (start) begin
          accept    = 1'b1;
          state_nxt = S_RUN;
        end
      end
      S_RUN: begin
        step = 1'b1;
        if (last) state_nxt = S_DONE;
      end
      S_DONE: begin
        // Back-to-back start is taken in the done cycle itself.
        if (start) begin
          accept    = 1'b1;
          state_nxt = S_RUN;
        end else begin
          state_nxt = S_IDLE;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= S_IDLE;
      op_a     <= '0;
      op_b     <= '0;
      borrow_r <= 1'b0;
      idx      <= '0;
      diff     <= '0;
      bout     <= 1'b0;
      zero     <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        op_a     <= a;
        op_b     <= b;
        borrow_r <= bin;
        idx      <= '0;
        diff     <= '0;
        bout     <= 1'b0;
        zero     <= 1'b0;
        busy     <= 1'b1;
        done     <= 1'b0;
      end else if (step) begin
        diff     <= diff_upd;
        borrow_r <= sbo;
        if (last) begin
          busy <= 1'b0;
          done <= 1'b1;
          bout <= sbo;
          zero <= (diff_upd == '0);
        end else begin
          idx <= idx + IW'(1);
        end
      end else begin
        done <= 1'b0;
      end
    end
  end

endmodule
